// File: rtl/traffic_countdown_display.sv
// Countdown display: sequential double-dabble BCD (capture to bcd_out in 10 clocks), 2-digit muxed 7-seg with yellow blink.
// Optional COUNTDOWN_DP_EN adds seg_dp for final seconds; there is no backpressure, and input changes during a conversion are picked up afterwards.
module traffic_countdown_display #(
    parameter int SCAN_DIV  = 12000,
    parameter int BLINK_DIV = 3000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] count_in,
    input  logic [2:0] light_main,
    output logic [6:0] seg_out,
    output logic [1:0] dig_sel,
    output logic [7:0] bcd_out,
    output logic       busy
`ifdef COUNTDOWN_DP_EN
    ,
    output logic       seg_dp
`endif
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_GREEN  = 3'b010;
    localparam logic [2:0] L_YELLOW = 3'b001;

    logic [1:0]         r_state;
    logic [19:0]        r_shift;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_last_val;
    logic               r_pending;
    logic               r_busy;
    logic [7:0]         r_bcd;
    logic [SCAN_W-1:0]  r_scan_cnt;
    logic               r_digit;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic [6:0]         r_seg;
    logic [1:0]         r_dig_sel;

    logic               w_capture;
    logic [19:0]        w_adj;
    logic [7:0]         w_sat;
    logic [7:0]         w_bcd_nxt;
    logic               w_scan_wrap;
    logic               w_digit_nxt;
    logic               w_yellow;
    logic               w_illegal;
    logic               w_blink_wrap;
    logic               w_phase_nxt;
    logic               w_blank;
    logic [6:0]         w_seg_nxt;

    function automatic logic [3:0] f_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Field layout {hundreds, tens, ones, binary}; adjust-then-shift each SHIFT cycle.
    assign w_capture = (r_state == S_IDLE) && ((count_in != r_last_val) || r_pending);
    assign w_adj     = {f_adj(r_shift[19:16]), f_adj(r_shift[15:12]), f_adj(r_shift[11:8]), r_shift[7:0]};
    assign w_sat     = (r_shift[19:16] != 4'd0) ? 8'h99 : r_shift[15:8];
    assign w_bcd_nxt = (r_state == S_DONE) ? w_sat : r_bcd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= 20'd0;
            r_bit_cnt  <= 3'd0;
            r_last_val <= 8'd0;
            r_pending  <= 1'b1;
            r_busy     <= 1'b0;
            r_bcd      <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_last_val <= count_in;
                        r_shift    <= {12'd0, count_in};
                        r_pending  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bit_cnt  <= 3'd0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shift   <= {w_adj[18:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bcd   <= w_sat;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_scan_wrap  = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign w_digit_nxt  = w_scan_wrap ? ~r_digit : r_digit;
    assign w_yellow     = (light_main == L_YELLOW);
    assign w_illegal    = !((light_main == L_RED) || (light_main == L_GREEN) || w_yellow);
    assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
    // Counter and phase are held clear outside yellow, so every entry into yellow starts on.
    assign w_phase_nxt  = w_yellow && (w_blink_wrap ? ~r_phase : r_phase);
    assign w_blank      = w_yellow && w_phase_nxt;

    always_comb begin
        w_seg_nxt = 7'h00;
        if (w_illegal) begin
            w_seg_nxt = 7'h40;
        end else if (w_blank) begin
            w_seg_nxt = 7'h00;
        end else if (!w_digit_nxt) begin
            w_seg_nxt = f_seg(w_bcd_nxt[3:0]);
        end else if (w_bcd_nxt[7:4] != 4'd0) begin
            w_seg_nxt = f_seg(w_bcd_nxt[7:4]);
        end
    end

    // Segment and digit registers are loaded from the same next-state values, avoiding ghosting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_digit     <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_seg       <= 7'h00;
            r_dig_sel   <= 2'b11;
        end else begin
            r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
            r_digit     <= w_digit_nxt;
            r_blink_cnt <= (!w_yellow || w_blink_wrap) ? '0 : r_blink_cnt + BLINK_W'(1);
            r_phase     <= w_phase_nxt;
            r_seg       <= w_seg_nxt;
            r_dig_sel   <= w_digit_nxt ? 2'b01 : 2'b10;
        end
    end

`ifdef COUNTDOWN_DP_EN
    logic r_dp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp <= 1'b0;
        end else begin
            r_dp <= !w_digit_nxt && !w_illegal && !w_blank &&
                    ((w_bcd_nxt == 8'h01) || (w_bcd_nxt == 8'h02));
        end
    end

    assign seg_dp = r_dp;
`endif

    assign seg_out = r_seg;
    assign dig_sel = r_dig_sel;
    assign bcd_out = r_bcd;
    assign busy    = r_busy;

endmodule

// File: tb/tb_traffic_countdown_display.sv
// Randomised bench for traffic_countdown_display against an arithmetic model of counts, scan slots and blink phase.
module tb_traffic_countdown_display;

    localparam int SCAN  = 5;
    localparam int BLINK = 40;
    localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] count_in = 8'd15;
    logic [2:0] light_main = 3'b010;
    logic [6:0] seg_out;
    logic [1:0] dig_sel;
    logic [7:0] bcd_out;
    logic       busy;
`ifdef COUNTDOWN_DP_EN
    logic       seg_dp;
`endif

    traffic_countdown_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_in   (count_in),
        .light_main (light_main),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .bcd_out    (bcd_out),
        .busy       (busy)
`ifdef COUNTDOWN_DP_EN
        ,
        .seg_dp     (seg_dp)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: edges since reset, conversion countdown, consecutive yellow edges.
    int         m_edges = 0;
    int         m_last  = 0;
    bit         m_pend  = 1'b1;
    bit         m_busy  = 1'b0;
    int         m_rem   = 0;
    int         m_val   = 0;
    int         m_bcd   = 0;
    int         m_ycnt  = 0;
    logic [2:0] m_light = 3'b010;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges <= 0;
            m_last  <= 0;
            m_pend  <= 1'b1;
            m_busy  <= 1'b0;
            m_rem   <= 0;
            m_val   <= 0;
            m_bcd   <= 0;
            m_ycnt  <= 0;
        end else begin
            m_edges <= m_edges + 1;
            if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_bcd  <= (m_val >= 100) ? 'h99 : (m_val / 10) * 16 + (m_val % 10);
                end
            end else if ((int'(count_in) != m_last) || m_pend) begin
                m_last <= int'(count_in);
                m_val  <= int'(count_in);
                m_pend <= 1'b0;
                m_busy <= 1'b1;
                m_rem  <= 9;
            end
            m_light <= light_main;
            m_ycnt  <= (light_main == 3'b001) ? m_ycnt + 1 : 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: wait for the falling edge, then compare every output with the model.
    task automatic tick();
        int  e_seg, e_dig, e_dp, digit;
        bit  illegal, off;
        @(negedge clk);
        e_seg = 0;
        e_dig = 3;
        e_dp  = 0;
        if (m_edges > 0) begin
            digit   = (m_edges / SCAN) % 2;
            illegal = !((m_light == 3'b100) || (m_light == 3'b010) || (m_light == 3'b001));
            off     = (m_light == 3'b001) && (((m_ycnt / BLINK) % 2) == 1);
            e_dig   = (digit == 1) ? 1 : 2;
            if (illegal)             e_seg = 'h40;
            else if (off)            e_seg = 0;
            else if (digit == 0)     e_seg = SEG_TBL[m_bcd % 16];
            else if (m_bcd / 16 != 0) e_seg = SEG_TBL[m_bcd / 16];
            e_dp = (digit == 0 && !illegal && !off && (m_bcd == 1 || m_bcd == 2)) ? 1 : 0;
        end
        chk("seg_out", int'(seg_out), e_seg);
        chk("dig_sel", int'(dig_sel), e_dig);
        chk("bcd_out", int'(bcd_out), m_bcd);
        chk("busy", int'(busy), int'(m_busy));
`ifdef COUNTDOWN_DP_EN
        chk("seg_dp", int'(seg_dp), e_dp);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_dig_sel", int'(dig_sel), 'h3);
        chk("reset_seg_out", int'(seg_out), 'h0);
        rst_n = 1'b1;

        // 15 on green: busy for 9 clocks, result on the 10th.
        repeat (9) tick();
        chk("lat15_busy", int'(busy), 1);
        chk("lat15_bcd_early", int'(bcd_out), 'h0);
        tick();
        chk("lat15_bcd", int'(bcd_out), 'h15);
        chk("lat15_busy_drop", int'(busy), 0);
        for (int i = 0; i < 2 * SCAN; i++) begin
            tick();
            chk("scan15", int'(seg_out), (dig_sel == 2'b10) ? 'h6D : 'h06);
        end

        // Changes during a conversion are picked up by a second conversion.
        count_in = 8'd20;
        tick();
        count_in = 8'd15;
        tick();
        count_in = 8'd14;
        tick();
        count_in = 8'd13;
        repeat (30) tick();
        chk("settle13", int'(bcd_out), 'h13);

        count_in = 8'd7;
        repeat (12) tick();
        chk("bcd7", int'(bcd_out), 'h07);
        for (int i = 0; i < 2 * SCAN; i++) begin
            tick();
            chk("blank_tens7", int'(seg_out), (dig_sel == 2'b10) ? 'h07 : 'h00);
        end

        count_in = 8'd200;
        repeat (12) tick();
        chk("sat200", int'(bcd_out), 'h99);
        for (int i = 0; i < 2 * SCAN; i++) begin
            tick();
            chk("sat_seg", int'(seg_out), 'h6F);
        end

        // Yellow blink with 2 displayed.
        count_in = 8'd2;
        repeat (12) tick();
        light_main = 3'b001;
        for (int k = 1; k <= 3 * BLINK; k++) begin
            tick();
            chk("blink", int'(seg_out),
                (((k / BLINK) % 2) == 1) ? 'h00 : ((dig_sel == 2'b10) ? 'h5B : 'h00));
        end

        for (int c = 0; c < 3; c++) begin
            light_main = (c == 0) ? 3'b000 : (c == 1) ? 3'b011 : 3'b111;
            for (int i = 0; i < 2 * SCAN + 2; i++) begin
                tick();
                chk("illegal_dash", int'(seg_out), 'h40);
            end
        end

        // Reset in the middle of a conversion, then recovery through the pending flag.
        light_main = 3'b100;
        count_in   = 8'd55;
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        chk("midrst_bcd", int'(bcd_out), 0);
        chk("midrst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("midrst_recover", int'(bcd_out), 'h55);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) count_in = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: light_main = 3'b100;
                    3, 4, 5: light_main = 3'b010;
                    6, 7, 8: light_main = 3'b001;
                    default: light_main = 3'($urandom_range(0, 7));
                endcase
            end
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
